// File: rtl/fifo_write_arbiter_if.sv
// Shared FIFO write-port bundle: producer valid/ready lanes plus the FIFO write side.
// The arbiter takes the slave view; the producers and FIFO together take the master view.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_w_en;
    logic [DATA_WIDTH-1:0]         fifo_data;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_w_en, fifo_data
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_w_en, fifo_data
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port, with burst lock up to MAX_BURST beats.
// Latency: zero cycles, request to FIFO write is purely combinational.
// Backpressure: fifo_full suppresses ready and write enable; grant and burst state hold.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    fifo_write_arbiter_if.slave        bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   last_owner, last_owner_nxt;
    logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
    logic [IW-1:0]   sel, gnt;
    logic            sel_found;
    logic            wr;

    // Search starts just past the previous owner so it gets lowest priority.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!sel_found && bus.req_valid[IW'((int'(last_owner) + k) % NUM_REQ)]) begin
                sel_found = 1'b1;
                sel       = IW'((int'(last_owner) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        beat_cnt_nxt   = beat_cnt;
        bus.req_ready  = '0;
        grant_id       = '0;
        busy           = 1'b0;
        gnt            = sel;
        wr             = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_id = sel;
                    if (!bus.fifo_full) begin
                        bus.req_ready[sel] = 1'b1;
                        wr                 = 1'b1;
                        if (bus.req_last[sel] || MAX_BURST == 1) begin
                            last_owner_nxt = sel;
                        end else begin
                            state_nxt    = BURST;
                            owner_nxt    = sel;
                            beat_cnt_nxt = CW'(1);
                        end
                    end
                end
            end
            BURST: begin
                // Lock holds even when the owner idles; other requesters wait.
                gnt                  = owner;
                busy                 = 1'b1;
                grant_id             = owner;
                bus.req_ready[owner] = !bus.fifo_full;
                wr                   = bus.req_valid[owner] && !bus.fifo_full;
                if (wr) begin
                    if (bus.req_last[owner] || (beat_cnt + CW'(1)) == CW'(MAX_BURST)) begin
                        state_nxt      = IDLE;
                        last_owner_nxt = owner;
                        beat_cnt_nxt   = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_w_en = wr;
        bus.fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr && IW'(i) == gnt) begin
                bus.fifo_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule
